// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU: boot and halt addresses and the fetch FSM states.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_DELAY,
        FETCH_HALTED
    } fetch_state_t;

endpackage

// File: rtl/mips_cpu_bswap32.sv
// Combinational 32-bit byte reversal between big-endian memory words and CPU byte order.
module mips_cpu_bswap32 (
    input  logic [31:0] data,
    output logic [31:0] swapped
);

    assign swapped = {data[7:0], data[15:8], data[23:16], data[31:24]};

endmodule

// File: rtl/mips_cpu_fetch.sv
// Instruction fetch: PC sequencing with one branch delay slot, halt detection and fetch counting.
module mips_cpu_fetch
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_readdata_be,
    output logic [31:0] instr_address,
    output logic [31:0] instr,
    output logic        active,
    output logic        addr_error,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  target, target_next;
    logic         err_next;
    logic [31:0]  count_next;

    mips_cpu_bswap32 u_bswap (
        .data    (instr_readdata_be),
        .swapped (instr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH_RUN;
            pc          <= RESET_VECTOR;
            target      <= 32'd0;
            addr_error  <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            target      <= target_next;
            addr_error  <= err_next;
            fetch_count <= count_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        target_next = target;
        err_next    = addr_error;
        count_next  = fetch_count;
        if (clk_enable) begin
            case (state)
                FETCH_RUN: begin
                    pc_next    = pc + PC_STEP;
                    count_next = fetch_count + 32'd1;
                    if (redirect_valid) begin
                        target_next = redirect_target;
                        state_next  = FETCH_DELAY;
                    end
                end
                // Delay slot already fetched; redirect requests here are dropped.
                FETCH_DELAY: begin
                    pc_next    = target;
                    count_next = fetch_count + 32'd1;
                    if (target == HALT_ADDR) begin
                        state_next = FETCH_HALTED;
                    end else if (target[1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        state_next = FETCH_HALTED;
                    end else begin
                        state_next = FETCH_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_address = pc;
    assign active        = (state != FETCH_HALTED);

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch: a vector table plus hand-written multi-cycle sequences.
module tb_mips_cpu_fetch;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_readdata_be;
    logic [31:0] instr_address;
    logic [31:0] instr;
    logic        active;
    logic        addr_error;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    mips_cpu_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .clk_enable        (clk_enable),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .instr_readdata_be (instr_readdata_be),
        .instr_address     (instr_address),
        .instr             (instr),
        .active            (active),
        .addr_error        (addr_error),
        .fetch_count       (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] rd;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_act;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_addr, input logic e_act,
                             input logic e_err, input logic [31:0] e_cnt);
        chk({tag, ".addr"},   instr_address, e_addr);
        chk({tag, ".active"}, {31'd0, active}, {31'd0, e_act});
        chk({tag, ".err"},    {31'd0, addr_error}, {31'd0, e_err});
        chk({tag, ".count"},  fetch_count, e_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rv, input logic [31:0] tgt);
        clk_enable      = en;
        redirect_valid  = rv;
        redirect_target = tgt;
    endtask

    // Assert reset away from the clock edge, check, release, leave inputs idle-enabled.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'd0);
        reset = 1'b0;
        #2;
        chk_state({tag, ".rst"}, 32'hBFC0_0000, 1'b1, 1'b0, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        reset             = 1'b0;
        clk_enable        = 1'b0;
        redirect_valid    = 1'b0;
        redirect_target   = 32'd0;
        instr_readdata_be = 32'd0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0800_0000, 32'hBFC0_0004, 32'h0000_0008, 1'b1, 1'b0, 32'd1};
        vecs[1] = '{1'b1, 1'b1, 32'hBFC0_0100, 32'h1234_5678, 32'hBFC0_0008, 32'h7856_3412, 1'b1, 1'b0, 32'd2};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'hBFC0_0100, 32'hEFBE_ADDE, 1'b1, 1'b0, 32'd3};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_00FF, 32'hBFC0_0104, 32'hFF00_0000, 1'b1, 1'b0, 32'd4};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0040, 32'hA1B2_C3D4, 32'hBFC0_0104, 32'hD4C3_B2A1, 1'b1, 1'b0, 32'd4};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0102_0304, 32'hBFC0_0108, 32'h0403_0201, 1'b1, 1'b0, 32'd5};
        vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_0000, 32'hBFC0_010C, 32'h0000_FFFF, 1'b1, 1'b0, 32'd6};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 32'd7};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0000, 32'h8000_0001, 32'h0000_0000, 32'h0100_0080, 1'b1, 1'b0, 32'd8};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 32'd9};

        // Reset state and table run.
        #12;
        chk_state("reset", 32'hBFC0_0000, 1'b1, 1'b0, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].en, vecs[i].rv, vecs[i].tgt);
            instr_readdata_be = vecs[i].rd;
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_act, vecs[i].e_err, vecs[i].e_cnt);
            chk($sformatf("vec%0d.instr", i), instr, vecs[i].e_instr);
        end

        // Sequential fetch from the reset vector.
        do_reset("seq");
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_state($sformatf("seq%0d", i), 32'hBFC0_0000 + 32'(4 * i), 1'b1, 1'b0, 32'(i));
        end

        // Redirect to the halt address, then stays halted with redirects ignored.
        do_reset("halt");
        drive(1'b1, 1'b1, 32'h0000_0000);
        step();
        chk_state("halt.slot", 32'hBFC0_0004, 1'b1, 1'b0, 32'd1);
        drive(1'b1, 1'b0, 32'd0);
        step();
        chk_state("halt.pc0", 32'h0000_0000, 1'b0, 1'b0, 32'd2);
        drive(1'b1, 1'b1, 32'hBFC0_0200);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_state($sformatf("halt.hold%0d", i), 32'h0000_0000, 1'b0, 1'b0, 32'd2);
        end

        // Stall while in the delay slot.
        do_reset("stall");
        step();
        drive(1'b1, 1'b1, 32'hBFC0_0100);
        step();
        chk_state("stall.slot", 32'hBFC0_0008, 1'b1, 1'b0, 32'd2);
        drive(1'b0, 1'b1, 32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_state($sformatf("stall.frz%0d", i), 32'hBFC0_0008, 1'b1, 1'b0, 32'd2);
        end
        drive(1'b1, 1'b0, 32'd0);
        step();
        chk_state("stall.tgt", 32'hBFC0_0100, 1'b1, 1'b0, 32'd3);
        step();
        chk_state("stall.next", 32'hBFC0_0104, 1'b1, 1'b0, 32'd4);

        // Misaligned target sets the sticky error; async reset clears it mid-cycle.
        do_reset("mis");
        drive(1'b1, 1'b1, 32'hBFC0_0102);
        step();
        chk_state("mis.slot", 32'hBFC0_0004, 1'b1, 1'b0, 32'd1);
        drive(1'b1, 1'b0, 32'd0);
        step();
        chk_state("mis.err", 32'hBFC0_0102, 1'b0, 1'b1, 32'd2);
        step();
        chk_state("mis.hold", 32'hBFC0_0102, 1'b0, 1'b1, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_state("mis.arst", 32'hBFC0_0000, 1'b1, 1'b0, 32'd0);
        reset = 1'b1;

        // Reset in the middle of a delay slot discards the pending target.
        do_reset("pend");
        drive(1'b1, 1'b1, 32'hBFC0_0100);
        step();
        drive(1'b1, 1'b0, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_state("pend.arst", 32'hBFC0_0000, 1'b1, 1'b0, 32'd0);
        reset = 1'b1;
        step();
        chk_state("pend.first", 32'hBFC0_0004, 1'b1, 1'b0, 32'd1);
        step();
        chk_state("pend.second", 32'hBFC0_0008, 1'b1, 1'b0, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_fetch.md
MIPS_CPU_FETCH -- requirements
Module: mips_cpu_fetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-003 SHALL have port clk_enable, input, 1, global stall; 0 holds all state.
REQ-004 SHALL have port redirect_valid, input, 1, control-transfer request from decode (branch taken or jump) for the instruction currently fetched.
REQ-005 SHALL have port redirect_target, input, 32, byte address of that transfer.
REQ-006 SHALL have port instr_readdata_be, input, 32, big-endian instruction word from instruction memory for instr_address.
REQ-007 SHALL have port instr_address, output, 32, current PC driven to instruction memory.
REQ-008 SHALL have port instr, output, 32, instruction in CPU byte order.
REQ-009 SHALL have port active, output, 1, high while executing; low once halted or after an address error.
REQ-010 SHALL have port addr_error, output, 1, sticky flag for a misaligned redirect target.
REQ-011 SHALL have port fetch_count, output, 32, number of instructions fetched since reset.

Function
REQ-012 SHALL drive instr combinationally as {instr_readdata_be[7:0], [15:8], [23:16], [31:24]}; zero latency.
REQ-013 SHALL implement states RUN, DELAY and HALTED, with the pending target held in a 32-bit register.
REQ-014 RUN, clk_enable=1, redirect_valid=0: SHALL set PC <= PC+4, with modulo-2^32 wrap (0xFFFFFFFC -> 0x00000000), and stay in RUN.
REQ-015 RUN, clk_enable=1, redirect_valid=1: SHALL set PC <= PC+4 (delay slot), latch redirect_target, and go to DELAY.
REQ-016 DELAY, clk_enable=1, latched target == 0x00000000: SHALL set PC <= 0 and go to HALTED.
REQ-017 DELAY, clk_enable=1, latched target[1:0] != 0: SHALL set PC <= latched target, set addr_error, and go to HALTED.
REQ-018 DELAY, clk_enable=1, any other latched target: SHALL set PC <= latched target and go to RUN.
REQ-019 DELAY: SHALL ignore redirect_valid (no branch in a delay slot); the latched target is not overwritten.
REQ-020 HALTED: SHALL hold PC, ignore redirect_valid, and drive active=0 until reset.
REQ-021 clk_enable=0: SHALL leave PC, state, latched target, addr_error and fetch_count unchanged and ignore redirect_valid.
REQ-022 fetch_count SHALL increment by 1 on each enabled edge in RUN or DELAY, wrap at 2^32, and hold in HALTED.
REQ-023 active SHALL be 1 in RUN and DELAY and 0 in HALTED, so PC==0 with active==0 is the halt signature.

Reset
REQ-024 reset=0 SHALL force PC=0xBFC00000, state RUN, latched target=0, addr_error=0, fetch_count=0 and active=1, including mid-DELAY and from HALTED.
REQ-025 After reset deasserts, the first enabled rising edge SHALL advance PC to 0xBFC00004; a pending redirect is discarded.

Structure
REQ-026 SHALL take RESET_VECTOR (0xBFC00000), HALT_ADDR (0x00000000) and the fetch state enum from the shared package mips_cpu_pkg.
REQ-027 SHALL put the byte swap in one sub-module, mips_cpu_bswap32 (32-bit in, 32-bit out, combinational), reusable by data memory.
REQ-028 SHALL be flat apart from that sub-module; the PC adder and state register live in mips_cpu_fetch.

Verification
REQ-029 Reset, then 3 enabled edges -> instr_address 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; fetch_count=3; active=1.
REQ-030 instr_readdata_be=0x08000000 -> instr=0x00000008 in the same cycle.
REQ-031 redirect_valid=1, target 0xBFC00100, at PC 0xBFC00004 -> next PC 0xBFC00008, then 0xBFC00100, then 0xBFC00104.
REQ-032 redirect to 0x00000000 at PC 0xBFC00000 -> PC 0xBFC00004, then 0x00000000 with active=0; PC held 10 further cycles.
REQ-033 clk_enable=0 for 5 cycles while in DELAY -> PC and fetch_count frozen; on re-enable PC=target.
REQ-034 redirect to 0xBFC00102 -> after the delay slot PC=0xBFC00102, addr_error=1, active=0; then reset=0 mid-cycle -> PC=0xBFC00000 and addr_error=0 immediately.
